param_expr_unit: RTL and testbench
==================================

Name: param_expr_unit

Overview:
- Streaming arithmetic stage that evaluates the elaboration-time expression set at run time: add, sub, mul, div, mod and clog2 on unsigned operands.
- Sits directly downstream of parameter/expression extraction. Consumes (opcode, operand A, operand B) tuples and produces registered results with an error flag.
- Used to cross-check extracted parameter values in hardware and to compute derived sizes in configurable cores.
- Single clock domain. Valid/ready handshake on both the input and the output side.

Parameters:
- DATA_WIDTH, 32, operand and result width in bits (minimum 2).
- CLOG2_WIDTH, $clog2(DATA_WIDTH)+1, width of the internal clog2 result before zero-extension.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- op_valid  in  1  input tuple valid.
- op_ready  out  1  unit can accept a tuple.
- op_code  in  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 CLOG2, 6-7 illegal.
- operand_a  in  DATA_WIDTH  first operand (unsigned).
- operand_b  in  DATA_WIDTH  second operand (unsigned); ignored by CLOG2.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- result  out  DATA_WIDTH  computed value.
- error  out  1  overflow, divide-by-zero or illegal opcode; qualified by res_valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - op_ready=0 while reset is asserted; op_ready=1 on the first clock edge after release.
  - res_valid=0, result=0, error=0, all divider registers cleared.
  - Reset asserted mid-divide aborts the operation and emits no result.
- FSM states: IDLE, DIVIDE, OUTPUT.
  - IDLE: op_ready=1. op_valid&&op_ready captures the tuple.
    - DIV/MOD with operand_b!=0 -> DIVIDE.
    - All other cases -> OUTPUT, with result and error registered on the same edge.
  - DIVIDE: restoring divider, one quotient bit per cycle, DATA_WIDTH cycles. Goes to OUTPUT on the last iteration.
  - OUTPUT: res_valid=1; result and error held stable until res_valid&&res_ready, then -> IDLE.
- op_ready=0 in DIVIDE and OUTPUT; no overlap. The earliest next accept is the cycle after the result handshake.
- Latency from accept edge to res_valid high:
  - 1 cycle for ADD/SUB/MUL/CLOG2, illegal opcodes and divide-by-zero.
  - DATA_WIDTH+1 cycles for DIV/MOD.
- Arithmetic is unsigned; result is truncated to DATA_WIDTH bits.
  - ADD: error=carry out.
  - SUB: error=borrow (a<b); result wraps modulo 2^DATA_WIDTH.
  - MUL: full 2*DATA_WIDTH product is formed; result=low half; error=|high half.
  - DIV: result=quotient. MOD: result=remainder. error=0.
  - Divide-by-zero: DIV result=all ones, MOD result=operand_a, error=1.
  - CLOG2: ceiling log2 of operand_a, clog2(0)=0, clog2(1)=0; zero-extended; error=0.
  - Illegal opcode: result=0, error=1.
- Inputs are sampled only at the accept edge. Changes to op_* while busy are ignored.
- res_ready high while res_valid is low has no effect.

Optional Feature:
- Macro PARAM_EXPR_CLOG2_EN.
- Defined: opcode 5 computes CLOG2 as specified.
- Undefined: the CLOG2 logic is removed; opcode 5 is treated as illegal (result=0, error=1, latency 1).

Decomposition:
- Package param_expr_pkg holds:
  - op_code_t enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_CLOG2.
  - fsm_state_t enum: IDLE, DIVIDE, OUTPUT.
  - Divide-by-zero result constants.
- Sub-module param_expr_divider: iterative restoring divider with start/done, quotient and remainder outputs, and its own asynchronous active-low reset. The top-level block owns the handshake and result muxing.

Test Plan (DATA_WIDTH=32):
- ADD a=32, b=8 -> result=40, error=0, res_valid on cycle 1 after accept. MUL 32*8 -> 256. SUB 32-8 -> 24. SUB 8-32 -> 0xFFFFFFE8, error=1.
- DIV 32/8 -> 4 and MOD 32%8 -> 0, res_valid exactly 33 cycles after accept. MOD 37%5 -> 2.
- DIV 32/0 -> 0xFFFFFFFF, error=1. MOD 32%0 -> 32, error=1. Both with latency 1.
- CLOG2 of 40 -> 6, of 42 -> 6, of 1 -> 0, of 0 -> 0, of 0x80000001 -> 32. With PARAM_EXPR_CLOG2_EN undefined: opcode 5 -> 0, error=1.
- Backpressure: hold res_ready=0 for 10 cycles after MUL 0x10000*0x10000 -> result=0 and error=1 held stable, op_ready=0 throughout; accept occurs only after res_ready rises.
- Reset pulse at cycle 10 of a DIV -> res_valid never rises, outputs are 0; the next ADD 1+1 -> 2 with normal latency.

Source files
------------

// File: rtl/param_expr_pkg.sv
// Shared types and constants for the param_expr_unit streaming arithmetic stage.
package param_expr_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_MUL   = 3'd2,
        OP_DIV   = 3'd3,
        OP_MOD   = 3'd4,
        OP_CLOG2 = 3'd5
    } op_code_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        OUTPUT = 2'd2
    } fsm_state_t;

    // Divide-by-zero: DIV returns an all-ones word, MOD returns the dividend.
    localparam logic DIV0_QUOT_FILL = 1'b1;
    localparam logic DIV0_ERROR     = 1'b1;
    localparam logic ILLEGAL_ERROR  = 1'b1;

endpackage

// File: rtl/param_expr_divider.sv
// Iterative restoring divider: one quotient bit per cycle, DATA_WIDTH cycles per divide.
// quotient/remainder present the values being committed and are final while done is high.
module param_expr_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
    logic [DATA_WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    logic [DATA_WIDTH:0]   partial_s;
    logic [DATA_WIDTH-1:0] trial_s;
    logic                  ge_s;

    // One restoring step: dvd_q shifts dividend bits out and quotient bits in.
    always_comb begin
        partial_s = {rem_q, dvd_q[DATA_WIDTH-1]};
        ge_s      = (partial_s >= {1'b0, dsr_q});
        trial_s   = partial_s[DATA_WIDTH-1:0] - dsr_q;
        quotient  = {dvd_q[DATA_WIDTH-2:0], ge_s};
        remainder = ge_s ? trial_s : partial_s[DATA_WIDTH-1:0];
        done      = busy_q && (cnt_q == {CNT_W{1'b0}});

        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            rem_d  = {DATA_WIDTH{1'b0}};
            dvd_d  = dividend;
            dsr_d  = divisor;
            cnt_d  = CNT_W'(DATA_WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = remainder;
            dvd_d  = quotient;
            cnt_d  = cnt_q - CNT_W'(1);
            busy_d = (cnt_q != {CNT_W{1'b0}});
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state registers; reset aborts any divide in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q  <= {DATA_WIDTH{1'b0}};
            dvd_q  <= {DATA_WIDTH{1'b0}};
            dsr_q  <= {DATA_WIDTH{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/param_expr_unit.sv
// Streaming unsigned add/sub/mul/div/mod/clog2 stage with valid/ready on both sides.
// Opcode 5 (CLOG2) is only implemented when PARAM_EXPR_CLOG2_EN is defined; otherwise it is illegal.
module param_expr_unit
    import param_expr_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CLOG2_WIDTH = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_code,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  error
);

    function automatic logic [CLOG2_WIDTH-1:0] ceil_log2(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0]  m;
        logic [CLOG2_WIDTH-1:0] r;
        m = v - DATA_WIDTH'(1);
        r = {CLOG2_WIDTH{1'b0}};
        if (v > DATA_WIDTH'(1)) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                r = m[i] ? CLOG2_WIDTH'(i + 1) : r;
            end
        end else begin
            r = {CLOG2_WIDTH{1'b0}};
        end
        return r;
    endfunction

    fsm_state_t            state_q, state_d;
    logic                  op_ready_q, op_ready_d;
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  error_q, error_d;
    logic                  is_mod_q, is_mod_d;

    logic [DATA_WIDTH:0]     sum_s;
    logic [DATA_WIDTH-1:0]   diff_s;
    logic [2*DATA_WIDTH-1:0] prod_s;
    logic [DATA_WIDTH-1:0]   imm_result_s;
    logic                    imm_error_s;
    logic                    accept_s;
    logic                    is_divmod_s;
    logic                    div_start_s;
    logic                    div_done_s;
    logic [DATA_WIDTH-1:0]   div_quo_s;
    logic [DATA_WIDTH-1:0]   div_rem_s;

    param_expr_divider #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_divider (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start_s),
        .dividend (operand_a),
        .divisor  (operand_b),
        .done     (div_done_s),
        .quotient (div_quo_s),
        .remainder(div_rem_s)
    );

    // Single-cycle results; DIV/MOD entries here only cover the divide-by-zero case.
    always_comb begin
        sum_s  = {1'b0, operand_a} + {1'b0, operand_b};
        diff_s = operand_a - operand_b;
        prod_s = (2*DATA_WIDTH)'(operand_a) * (2*DATA_WIDTH)'(operand_b);
        imm_result_s = {DATA_WIDTH{1'b0}};
        imm_error_s  = 1'b0;
        case (op_code)
            OP_ADD: begin
                imm_result_s = sum_s[DATA_WIDTH-1:0];
                imm_error_s  = sum_s[DATA_WIDTH];
            end
            OP_SUB: begin
                imm_result_s = diff_s;
                imm_error_s  = (operand_a < operand_b);
            end
            OP_MUL: begin
                imm_result_s = prod_s[DATA_WIDTH-1:0];
                imm_error_s  = |prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            OP_DIV: begin
                imm_result_s = {DATA_WIDTH{DIV0_QUOT_FILL}};
                imm_error_s  = DIV0_ERROR;
            end
            OP_MOD: begin
                imm_result_s = operand_a;
                imm_error_s  = DIV0_ERROR;
            end
`ifdef PARAM_EXPR_CLOG2_EN
            OP_CLOG2: begin
                imm_result_s = DATA_WIDTH'(ceil_log2(operand_a));
                imm_error_s  = 1'b0;
            end
`endif
            default: begin
                imm_result_s = {DATA_WIDTH{1'b0}};
                imm_error_s  = ILLEGAL_ERROR;
            end
        endcase
    end

    // Handshake FSM: accept in IDLE, iterate in DIVIDE, hold the result in OUTPUT.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        error_d     = error_q;
        is_mod_d    = is_mod_q;
        div_start_s = 1'b0;
        accept_s    = op_valid && op_ready_q;
        is_divmod_s = (op_code == OP_DIV) || (op_code == OP_MOD);
        case (state_q)
            IDLE: begin
                if (accept_s && is_divmod_s && (operand_b != {DATA_WIDTH{1'b0}})) begin
                    state_d     = DIVIDE;
                    div_start_s = 1'b1;
                    is_mod_d    = (op_code == OP_MOD);
                end else if (accept_s) begin
                    state_d  = OUTPUT;
                    result_d = imm_result_s;
                    error_d  = imm_error_s;
                end else begin
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                if (div_done_s) begin
                    state_d  = OUTPUT;
                    result_d = is_mod_q ? div_rem_s : div_quo_s;
                    error_d  = 1'b0;
                end else begin
                    state_d = DIVIDE;
                end
            end
            OUTPUT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUTPUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        op_ready_d  = (state_d == IDLE);
        res_valid_d = (state_d == OUTPUT);
    end

    // Control and result registers; all handshake outputs come straight from flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            result_q    <= {DATA_WIDTH{1'b0}};
            error_q     <= 1'b0;
            is_mod_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
            error_q     <= error_d;
            is_mod_q    <= is_mod_d;
        end
    end

    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign result    = result_q;
    assign error     = error_q;

endmodule

// File: tb/tb_param_expr_unit.sv
// Scoreboard bench for param_expr_unit (DATA_WIDTH=32): expectations are queued at issue and popped at result.
module tb_param_expr_unit;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_code;
    logic [DW-1:0] operand_a;
    logic [DW-1:0] operand_b;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] result;
    logic          error;

    typedef struct {
        string         name;
        logic [2:0]    code;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
        logic          err;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    param_expr_unit #(.DATA_WIDTH(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .result   (result),
        .error    (error)
    );

    always #5 clock = ~clock;

    // Issue one tuple, scramble inputs while busy, return result/error and accept-to-valid latency (-1 on timeout).
    task automatic run_op(input logic [2:0] code, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] r, output logic e, output int lat);
        int n;
        r = '0; e = 1'b0; lat = -1;
        n = 0;
        while (op_ready !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
        if (op_ready !== 1'b1) return;
        op_valid = 1'b1; op_code = code; operand_a = a; operand_b = b;
        @(posedge clock); #1;
        op_valid = 1'b0; op_code = 3'($urandom_range(0, 7)); operand_a = $urandom; operand_b = $urandom;
        n = 1;
        while (res_valid !== 1'b1 && n < 200) begin @(posedge clock); #1; n++; end
        if (res_valid !== 1'b1) return;
        lat = n; r = result; e = error;
        res_ready = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
        op_code = 3'd0; operand_a = '0; operand_b = '0;
        #12;
        n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL reset_op_ready: got %b expected 0", op_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        n_checks++; if (result !== 32'h0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_outputs: got %h/%b expected 0/0", result, error); end
        #10 reset = 1'b1;
        @(posedge clock); #1;
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL release_op_ready: got %b expected 1", op_ready); end
    endtask

    task automatic test_table(input exp_t tbl[]);
        logic [DW-1:0] r; logic e; int lat; exp_t x;
        foreach (tbl[i]) begin
            sb.push_back(tbl[i]);
            run_op(tbl[i].code, tbl[i].a, tbl[i].b, r, e, lat);
            x = sb.pop_front();
            n_checks++; if (r !== x.res) begin n_fail++; $display("FAIL %s result: got %h expected %h", x.name, r, x.res); end
            n_checks++; if (e !== x.err) begin n_fail++; $display("FAIL %s error: got %b expected %b", x.name, e, x.err); end
            n_checks++; if (lat !== x.lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", x.name, lat, x.lat); end
        end
    endtask

    task automatic test_arith();
        exp_t t[] = '{
            '{"add_32_8",   3'd0, 32'd32, 32'd8, 32'd40,        1'b0, 1},
            '{"mul_32_8",   3'd2, 32'd32, 32'd8, 32'd256,       1'b0, 1},
            '{"sub_32_8",   3'd1, 32'd32, 32'd8, 32'd24,        1'b0, 1},
            '{"sub_8_32",   3'd1, 32'd8, 32'd32, 32'hFFFFFFE8,  1'b1, 1},
            '{"add_carry",  3'd0, 32'hFFFFFFFF, 32'd2, 32'd1,   1'b1, 1},
            '{"illegal_6",  3'd6, 32'd5, 32'd5, 32'd0,          1'b1, 1},
            '{"illegal_7",  3'd7, 32'd5, 32'd5, 32'd0,          1'b1, 1}
        };
        test_table(t);
    endtask

    task automatic test_div_mod();
        exp_t t[] = '{
            '{"div_32_8",   3'd3, 32'd32, 32'd8, 32'd4,         1'b0, DW+1},
            '{"mod_32_8",   3'd4, 32'd32, 32'd8, 32'd0,         1'b0, DW+1},
            '{"mod_37_5",   3'd4, 32'd37, 32'd5, 32'd2,         1'b0, DW+1},
            '{"div_big",    3'd3, 32'hFFFFFFFF, 32'd7, 32'h24924924, 1'b0, DW+1},
            '{"div_32_0",   3'd3, 32'd32, 32'd0, 32'hFFFFFFFF,  1'b1, 1},
            '{"mod_32_0",   3'd4, 32'd32, 32'd0, 32'd32,        1'b1, 1}
        };
        test_table(t);
    endtask

    task automatic test_clog2();
`ifdef PARAM_EXPR_CLOG2_EN
        exp_t t[] = '{
            '{"clog2_40",   3'd5, 32'd40, 32'd9, 32'd6,         1'b0, 1},
            '{"clog2_42",   3'd5, 32'd42, 32'd0, 32'd6,         1'b0, 1},
            '{"clog2_1",    3'd5, 32'd1,  32'd3, 32'd0,         1'b0, 1},
            '{"clog2_0",    3'd5, 32'd0,  32'd3, 32'd0,         1'b0, 1},
            '{"clog2_top",  3'd5, 32'h80000001, 32'd0, 32'd32,  1'b0, 1}
        };
`else
        exp_t t[] = '{
            '{"clog2_off_40", 3'd5, 32'd40, 32'd9, 32'd0,       1'b1, 1},
            '{"clog2_off_0",  3'd5, 32'd0,  32'd0, 32'd0,       1'b1, 1}
        };
`endif
        test_table(t);
    endtask

    task automatic test_backpressure();
        exp_t x; int n; bit bad;
        sb.push_back('{"bp_mul", 3'd2, 32'h10000, 32'h10000, 32'd0, 1'b1, 1});
        sb.push_back('{"bp_add", 3'd0, 32'd5, 32'd5, 32'd10, 1'b0, 1});
        n = 0;
        while (op_ready !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
        op_valid = 1'b1; op_code = 3'd2; operand_a = 32'h10000; operand_b = 32'h10000;
        @(posedge clock); #1;
        op_code = 3'd0; operand_a = 32'd5; operand_b = 32'd5;
        x = sb.pop_front();
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_mul_valid: got %b expected 1", res_valid); end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b1 || result !== x.res || error !== x.err || op_ready !== 1'b0) bad = 1'b1;
            @(posedge clock); #1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL bp_hold: got %b/%h/%b/%b expected 1/%h/%b/0", res_valid, result, error, op_ready, x.res, x.err); end
        res_ready = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0;
        n_checks++; if (op_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got ready %b valid %b expected 1/0", op_ready, res_valid); end
        @(posedge clock); #1;
        op_valid = 1'b0;
        x = sb.pop_front();
        n_checks++; if (res_valid !== 1'b1 || result !== x.res || error !== x.err) begin n_fail++; $display("FAIL %s: got %b/%h/%b expected 1/%h/%b", x.name, res_valid, result, error, x.res, x.err); end
        res_ready = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        logic [DW-1:0] r; logic e; int lat; int n; bit seen; exp_t x;
        n = 0;
        while (op_ready !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
        op_valid = 1'b1; op_code = 3'd3; operand_a = 32'd32; operand_b = 32'd8;
        @(posedge clock); #1;
        op_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        n_checks++; if (res_valid !== 1'b0 || result !== 32'h0 || error !== 1'b0 || op_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_outputs: got %b/%h/%b/%b expected 0/0/0/0", res_valid, result, error, op_ready); end
        @(posedge clock); #1 reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin @(posedge clock); #1; if (res_valid === 1'b1) seen = 1'b1; end
        n_checks++; if (seen) begin n_fail++; $display("FAIL abort_no_result: got res_valid 1 expected 0"); end
        sb.push_back('{"post_reset_add", 3'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1});
        run_op(3'd0, 32'd1, 32'd1, r, e, lat);
        x = sb.pop_front();
        n_checks++; if (r !== x.res || e !== x.err || lat !== x.lat) begin
            n_fail++; $display("FAIL %s: got %h/%b/%0d expected %h/%b/%0d", x.name, r, e, lat, x.res, x.err, x.lat); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a, b, r; logic e; int lat; exp_t t, x;
        logic [DW:0] s; logic [2*DW-1:0] p;
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom;
            t.code = 3'(i % 5); t.a = a; t.lat = 1; t.name = "b2b";
            case (t.code)
                3'd0: begin s = {1'b0, a} + {1'b0, b}; t.res = s[DW-1:0]; t.err = s[DW]; end
                3'd1: begin t.res = a - b; t.err = (a < b); end
                3'd2: begin a = a & 32'h1FFFF; p = {32'h0, a} * {32'h0, b}; t.res = p[DW-1:0]; t.err = |p[2*DW-1:DW]; t.a = a; end
                3'd3: begin b = 32'($urandom_range(1, 1000)); t.res = a / b; t.err = 1'b0; t.lat = DW + 1; end
                default: begin b = 32'($urandom_range(1, 1000)); t.res = a % b; t.err = 1'b0; t.lat = DW + 1; end
            endcase
            t.b = b;
            sb.push_back(t);
            run_op(t.code, t.a, t.b, r, e, lat);
            x = sb.pop_front();
            n_checks++; if (r !== x.res || e !== x.err || lat !== x.lat) begin
                n_fail++; $display("FAIL %s op%0d: got %h/%b/%0d expected %h/%b/%0d", x.name, x.code, r, e, lat, x.res, x.err, x.lat); end
            n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_handshake: got %b expected 1", op_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_div_mod();
        test_clog2();
        test_backpressure();
        test_reset_mid_div();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
